// File: rtl/crc16_pkg.sv
// Shared CRC-16 types, polynomials and the serial step function.
package crc16_pkg;

  typedef logic [15:0] crc16_t;

  localparam crc16_t CRC16_CCITT_POLY = 16'h1021;
  localparam crc16_t CRC16_IBM_POLY   = 16'h8005;

  // 16 MSB-first LFSR steps; d[15] enters first.
  function automatic crc16_t crc16_next(
    input crc16_t c,
    input crc16_t d,
    input crc16_t poly
  );
    crc16_t r;
    logic   fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc16_d16_next.sv
// Combinational fold of one 16-bit word into a CRC-16 value.
module crc16_d16_next
  import crc16_pkg::*;
#(
  parameter crc16_t POLY = CRC16_CCITT_POLY
) (
  input  logic [15:0] c,
  input  logic [15:0] d,
  output logic [15:0] nxt
);

  always_comb begin
    nxt = crc16_next(c, d, POLY);
  end

endmodule

// File: rtl/crc16_d16.sv
// Parallel CRC-16, one data word per clock.
// Registered output; reset and sync both reload INIT.
module crc16_d16
  import crc16_pkg::*;
#(
  parameter crc16_t POLY = CRC16_CCITT_POLY,
  parameter crc16_t INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic [15:0] Data,
  output logic [15:0] newcrc
);

  crc16_t crc_q;
  crc16_t crc_d;
  crc16_t fold;

  crc16_d16_next #(
    .POLY(POLY)
  ) u_next (
    .c  (crc_q),
    .d  (Data),
    .nxt(fold)
  );

  // The mux keeps an X on Data out of the register.
  always_comb begin
    crc_d = fold;
    if (reset || sync) begin
      crc_d = INIT;
    end
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign newcrc = crc_q;

endmodule

// File: tb/tb_crc16_d16.sv
// Scoreboard bench for crc16_d16.
// Bit-serial reference model; outputs sampled 1ns after posedge.
module tb_crc16_d16;

  logic        clk;
  logic        reset;
  logic        sync;
  logic [15:0] Data;
  logic [15:0] newcrc;

  int n_cmp;
  int n_bad;

  logic [15:0] model;
  logic [15:0] sb[$];

  crc16_d16 dut (
    .clk   (clk),
    .reset (reset),
    .sync  (sync),
    .Data  (Data),
    .newcrc(newcrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_fold(
    input logic [15:0] c,
    input logic [15:0] d
  );
    logic [15:0] s;
    logic        b;
    s = c;
    for (int k = 0; k < 16; k++) begin
      b = s[15] ^ d[15-k];
      s = s << 1;
      if (b) s = s ^ 16'h1021;
    end
    return s;
  endfunction

  task automatic step(
    input string       tag,
    input logic        r,
    input logic        s,
    input logic [15:0] d
  );
    logic [15:0] exp;
    reset = r;
    sync  = s;
    Data  = d;
    if (r || s) model = 16'h0000;
    else        model = ref_fold(model, d);
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, newcrc, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model = 16'h0000;
    reset = 1'b1;
    sync  = 1'b0;
    Data  = 16'hxxxx;

    for (int i = 0; i < 3; i++)
      step("rst_hold", 1'b1, 1'b0, 16'hxxxx);
    step("rst_to_sync", 1'b0, 1'b1, 16'hxxxx);
    step("sync_hold", 1'b0, 1'b1, 16'hxxxx);

    step("single", 1'b0, 1'b0, 16'hAAAA);
    chk("single_lit", newcrc, 16'hE615);

    step("sync_a", 1'b0, 1'b1, 16'hxxxx);
    step("impulse", 1'b0, 1'b0, 16'h0001);
    chk("impulse_lit", newcrc, 16'h1021);

    step("sync_b", 1'b0, 1'b1, 16'hxxxx);
    for (int i = 0; i < 10; i++) begin
      step("zero", 1'b0, 1'b0, 16'h0000);
      chk("zero_lit", newcrc, 16'h0000);
    end

    step("sync_c", 1'b0, 1'b1, 16'hxxxx);
    for (int i = 0; i < 8; i++)
      step("stream", 1'b0, 1'b0, 16'hAAAA);

    step("mid_sync", 1'b0, 1'b1, 16'hxxxx);
    chk("mid_sync_lit", newcrc, 16'h0000);
    step("restart", 1'b0, 1'b0, 16'hAAAA);
    chk("restart_lit", newcrc, 16'hE615);
    step("restart2", 1'b0, 1'b0, 16'h1234);

    step("mid_rst", 1'b1, 1'b0, 16'h5A5A);
    chk("mid_rst_lit", newcrc, 16'h0000);

    step("sync_d", 1'b0, 1'b1, 16'hxxxx);
    step("pre_both", 1'b0, 1'b0, 16'hBEEF);
    step("pre_both2", 1'b0, 1'b0, 16'hCAFE);
    step("both", 1'b1, 1'b1, 16'hxxxx);
    chk("both_lit", newcrc, 16'h0000);

    for (int i = 0; i < 24; i++)
      step("rand", 1'b0, 1'b0, 16'($urandom));
    step("rand_sync", 1'b0, 1'b1, 16'hxxxx);
    for (int i = 0; i < 12; i++)
      step("rand2", 1'b0, 1'b0, 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
